button_debouncer: RTL and testbench

- Input-side counterpart to the LED pattern drivers: conditions N raw push-button/switch inputs into clean, glitch-free levels plus single-cycle event pulses.
- Sits between the board pins and user logic (speed/direction control of LED effects, mode select).
- Per-button debounce state machine on a shared 1 ms tick derived from the 12 MHz board clock.

---
 rtl/button_debouncer.sv | 206 ++++++++++++++++++++
 tb/tb_button_debouncer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Debounces N raw button inputs on a shared 1 ms tick, producing clean levels plus press/release pulses.
// Optional long-press detection is built when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.

module button_debouncer_chan #(
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000,
    parameter int CW            = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_s,
    input  logic i_tick,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam logic [CW-1:0] DB_C = CW'(DEBOUNCE_MS);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_done;

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_done    = i_tick && (w_cnt_inc == DB_C);

    if ((LONG_PRESS_MS <= DEBOUNCE_MS) || (LONG_PRESS_MS > 65535)) begin : g_bad_long
        $error("button_debouncer: LONG_PRESS_MS must be > DEBOUNCE_MS and <= 65535");
    end

    // An s change always wins over a coincident tick: the wait restarts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!i_s) begin
                        r_state <= IDLE;
                    end else if (w_done) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else if (i_tick) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!i_s) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (i_s) begin
                        r_state <= PRESSED;
                    end else if (w_done) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else if (i_tick) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam logic [15:0] LP_C = 16'(LONG_PRESS_MS);

    logic [15:0] r_hold;
    logic        r_long;
    logic [15:0] w_hold_inc;
    logic        w_holding;

    assign w_hold_inc = r_hold + 16'd1;
    assign w_holding  = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

    // Saturating at LP_C makes the pulse fire once; only a fresh accepted press re-arms it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if ((r_state == PRESS_WAIT) && i_s && w_done) begin
                r_hold <= '0;
            end else if (i_tick && w_holding && (r_hold != LP_C)) begin
                r_hold <= w_hold_inc;
                if (w_hold_inc == LP_C) r_long <= 1'b1;
            end
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif
endmodule

module button_debouncer #(
    parameter int CLK_FREQ      = 12_000_000,
    parameter int N_BTN         = 4,
    parameter int DEBOUNCE_MS   = 20,
    parameter int ACTIVE_LOW    = 0,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_IN,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE,
    output logic [N_BTN-1:0] BTN_LONG
);
    localparam int TICK_P = CLK_FREQ / 1000;
    localparam int TW     = (TICK_P > 1) ? $clog2(TICK_P) : 1;
    localparam int CW     = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;

    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_P - 1);
    localparam logic [N_BTN-1:0] REL_LVL   = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    if (TICK_P < 2) begin : g_bad_tick
        $error("button_debouncer: CLK_FREQ/1000 must be >= 2");
    end
    if ((N_BTN < 1) || (N_BTN > 16)) begin : g_bad_nbtn
        $error("button_debouncer: N_BTN must be 1..16");
    end
    if ((DEBOUNCE_MS < 1) || (DEBOUNCE_MS > 255)) begin : g_bad_db
        $error("button_debouncer: DEBOUNCE_MS must be 1..255");
    end

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [TW-1:0]    r_tick_cnt;
    logic [N_BTN-1:0] w_s;
    logic             w_tick;

    // Sync flops reset to the released pin level so reset never looks like a press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= REL_LVL;
            r_sync2 <= REL_LVL;
        end else begin
            r_sync1 <= BTN_IN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2 ^ REL_LVL;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        button_debouncer_chan #(
            .DEBOUNCE_MS   (DEBOUNCE_MS),
            .LONG_PRESS_MS (LONG_PRESS_MS),
            .CW            (CW)
        ) u_chan (
            .i_clk     (CLK),
            .i_rst     (RST),
            .i_s       (w_s[g]),
            .i_tick    (w_tick),
            .o_level   (BTN_LEVEL[g]),
            .o_press   (BTN_PRESS[g]),
            .o_release (BTN_RELEASE[g]),
            .o_long    (BTN_LONG[g])
        );
    end
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: one active-high and one active-low instance, P = 10 cycles.
module tb_button_debouncer;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_a, rst_b;
    logic [N-1:0] btn_a, btn_b;
    logic [N-1:0] a_lvl, a_prs, a_rel, a_lng;
    logic [N-1:0] b_lvl, b_prs, b_rel, b_lng;

    always #5 clk = ~clk;

    button_debouncer #(.CLK_FREQ(10_000), .N_BTN(N), .DEBOUNCE_MS(3), .ACTIVE_LOW(0), .LONG_PRESS_MS(8)) dut_a (
        .CLK(clk), .RST(rst_a), .BTN_IN(btn_a), .BTN_LEVEL(a_lvl),
        .BTN_PRESS(a_prs), .BTN_RELEASE(a_rel), .BTN_LONG(a_lng));

    button_debouncer #(.CLK_FREQ(10_000), .N_BTN(N), .DEBOUNCE_MS(3), .ACTIVE_LOW(1), .LONG_PRESS_MS(8)) dut_b (
        .CLK(clk), .RST(rst_b), .BTN_IN(btn_b), .BTN_LEVEL(b_lvl),
        .BTN_PRESS(b_prs), .BTN_RELEASE(b_rel), .BTN_LONG(b_lng));

    int cyc = 0, n_tot = 0, n_pass = 0, n_fail = 0, both = 0, long_any = 0;
    int a_pc[N], a_rc[N], a_lc[N], a_pcyc[N], a_rcyc[N], a_lcyc[N], a_rise[N], a_fall[N], a_seen[N];
    int b_pc[N], b_rc[N], b_lc[N], b_rise[N];
    logic [N-1:0] a_prev, b_prev;
    int t0, k;

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            a_pc[i] = 0; a_rc[i] = 0; a_lc[i] = 0; a_seen[i] = 0;
            a_pcyc[i] = -1; a_rcyc[i] = -1; a_lcyc[i] = -1; a_rise[i] = -1; a_fall[i] = -1;
            b_pc[i] = 0; b_rc[i] = 0; b_lc[i] = 0; b_rise[i] = -1;
        end
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (a_prs[i]) begin a_pc[i]++; a_pcyc[i] = cyc; end
                if (a_rel[i]) begin a_rc[i]++; a_rcyc[i] = cyc; end
                if (a_lng[i]) begin a_lc[i]++; a_lcyc[i] = cyc; end
                if (a_lvl[i] && !a_prev[i]) a_rise[i] = cyc;
                if (!a_lvl[i] && a_prev[i]) a_fall[i] = cyc;
                if (a_lvl[i]) a_seen[i] = 1;
                if (b_prs[i]) b_pc[i]++;
                if (b_rel[i]) b_rc[i]++;
                if (b_lng[i]) b_lc[i]++;
                if (b_lvl[i] && !b_prev[i]) b_rise[i] = cyc;
                if ((a_prs[i] && a_rel[i]) || (b_prs[i] && b_rel[i])) both++;
                if (a_lng[i] || b_lng[i]) long_any++;
            end
            a_prev = a_lvl;
            b_prev = b_lvl;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_tot++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        btn_a = '0;   btn_b = '1;
        a_prev = '0;  b_prev = '0;
        clr();
        step(5);
        chk("rst_lvl_a",   int'(a_lvl), 0);
        chk("rst_pulse_a", int'(a_prs | a_rel | a_lng), 0);
        chk("rst_out_b",   int'(b_lvl | b_prs | b_rel | b_lng), 0);

        rst_a = 1'b0; rst_b = 1'b0;
        clr();
        step(100);
        k = 0;
        for (int i = 0; i < N; i++) k += a_pc[i] + a_rc[i] + a_lc[i] + b_pc[i] + b_rc[i] + b_lc[i];
        chk("idle_pulses", k, 0);
        chk("idle_lvl", int'(a_lvl | b_lvl), 0);

        // clean press on channel 0, held 200 cycles
        clr();
        t0 = cyc; btn_a[0] = 1'b1; k = 0;
        while (!a_lvl[0] && k < 60) begin step(1); k++; end
        chk_rng("press0_lat", a_rise[0] - t0, 23, 33);
        chk("press0_same_cyc", a_pcyc[0], a_rise[0]);
        step(200 - (cyc - t0));
        chk("press0_cnt", a_pc[0], 1);
        chk("others_quiet", a_pc[1] + a_pc[2] + a_pc[3] + a_rc[1] + a_rc[2] + a_rc[3]
                            + a_seen[1] + a_seen[2] + a_seen[3], 0);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        chk("long0_cnt", a_lc[0], 1);
        chk_rng("long0_dly", a_lcyc[0] - a_pcyc[0], 71, 81);
`else
        chk("long0_cnt", a_lc[0], 0);
`endif
        btn_a[0] = 1'b0;
        step(40);
        chk("release0_cnt", a_rc[0], 1);
        chk("level0_low", int'(a_lvl[0]), 0);

        // channel 1 bouncing every 7 cycles never qualifies
        clr();
        for (int j = 0; j < 100; j++) begin
            if (j % 7 == 0) btn_a[1] = ~btn_a[1];
            step(1);
        end
        btn_a[1] = 1'b0;
        step(60);
        chk("bounce1_seen", a_seen[1], 0);
        chk("bounce1_pulses", a_pc[1] + a_rc[1], 0);

        // channel 2: accepted press, 5-cycle low glitch, then real release
        clr();
        btn_a[2] = 1'b1; k = 0;
        while (!a_lvl[2] && k < 60) begin step(1); k++; end
        step(10);
        btn_a[2] = 1'b0; step(5);
        btn_a[2] = 1'b1; step(40);
        chk("glitch2_no_rel", a_rc[2], 0);
        chk("glitch2_level", int'(a_lvl[2]), 1);
        chk("glitch2_one_press", a_pc[2], 1);
        t0 = cyc; btn_a[2] = 1'b0; k = 0;
        while (a_lvl[2] && k < 60) begin step(1); k++; end
        chk_rng("rel2_lat", a_fall[2] - t0, 23, 33);
        step(2);
        chk("rel2_cnt", a_rc[2], 1);
        chk("rel2_same_cyc", a_rcyc[2], a_fall[2]);

        // active-low instance: press channel 3, reset while held, re-debounce
        clr();
        t0 = cyc; btn_b[3] = 1'b0; k = 0;
        while (!b_lvl[3] && k < 60) begin step(1); k++; end
        chk_rng("b_press_lat", b_rise[3] - t0, 23, 33);
        step(20);
        chk("b_press_cnt", b_pc[3], 1);
        clr();
        rst_b = 1'b1;
        step(3);
        chk("b_rst_lvl", int'(b_lvl), 0);
        chk("b_rst_pulses", b_pc[3] + b_rc[3] + b_lc[3], 0);
        t0 = cyc; rst_b = 1'b0; k = 0;
        while (!b_lvl[3] && k < 60) begin step(1); k++; end
        chk("b_repress_lat", b_rise[3] - t0, 30);
        step(2);
        chk("b_repress_cnt", b_pc[3], 1);
        chk("b_no_release", b_rc[3], 0);
        btn_b[3] = 1'b1;
        step(40);
        chk("b_release_cnt", b_rc[3], 1);

        chk("press_release_overlap", both, 0);
`ifndef BUTTON_DEBOUNCER_LONG_PRESS_EN
        chk("long_never", long_any, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
